// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the shared downstream memory to the fetch or the data port, one transaction at a time
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_read/i_addr             fetch-side read request (held until i_resp)
//   i_rdata/i_resp            fetch-side read data, one-cycle completion
//   d_read/d_write/d_addr     data-side request (held until d_resp)
//   d_wdata                   data-side write data
//   d_rdata/d_resp            data-side read data, one-cycle completion
//   m_read/m_write            downstream strobes
//   m_addr/m_wdata            downstream address / write data
//   m_rdata/m_resp            downstream read data, one-cycle completion
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//   When defined, fetch is granted after STARVE_LIMIT consecutive data grants
//   taken while fetch was waiting.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_resp
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_I = 2'd1;
   localparam logic [1:0] GRANT_D = 2'd2;
   logic [1:0] state, nxt;
   logic       gi, gd, d_req, take_i;
   assign gi    = state == GRANT_I;
   assign gd    = state == GRANT_D;
   assign d_req = d_read | d_write;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
   logic [CW-1:0] cnt;
   // fetch wins the IDLE decision when data is absent or data has used up its run
   assign take_i = i_read & (~d_req | (cnt == LIMIT));
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (state == IDLE && nxt == GRANT_I)
         cnt <= '0;
      else if (state == IDLE && nxt == GRANT_D && i_read)
         cnt <= cnt + CW'(1);
   end
`else
   assign take_i = i_read & ~d_req;
`endif
   always_comb begin
      nxt = IDLE;
      if (state == IDLE)
         nxt = take_i ? GRANT_I : d_req ? GRANT_D : IDLE;
      else if (gi || gd)
         nxt = m_resp ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end
   // write wins over an illegal simultaneous read
   assign m_write = gd & d_write;
   assign m_read  = gd ? (d_read & ~d_write) : (gi & i_read);
   assign m_addr  = gd ? d_addr : gi ? i_addr : '0;
   assign m_wdata = gd ? d_wdata : '0;
   assign i_resp  = gi & m_resp;
   assign d_resp  = gd & m_resp;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!(d_read && d_write));
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic         i_read;
   logic [15:0]  i_addr;
   logic [127:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [15:0]  d_addr;
   logic [127:0] d_wdata;
   logic [127:0] d_rdata;
   logic         d_resp;
   logic         m_read;
   logic         m_write;
   logic [15:0]  m_addr;
   logic [127:0] m_wdata;
   logic [127:0] m_rdata;
   logic         m_resp;
   int tests = 0;
   int fails = 0;
   localparam logic [127:0] PAT_A5 = {16{8'hA5}};
   localparam logic [127:0] PAT_WD = {8{16'h1234}};

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(128), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_resp(m_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
      d_wdata = '0; m_rdata = '0; m_resp = 0;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1;
      next_cycle();
      next_cycle();
      rst = 0;
      for (int c = 0; c < 5; c++) begin
         mid();
         tests++;
         if ({m_read, m_write, i_resp, d_resp} !== 4'b0 || m_addr !== 16'h0 || m_wdata !== '0) begin
            fails++;
            $display("FAIL reset_idle c%0d: rd=%b wr=%b ir=%b dr=%b addr=%h, required all 0", c, m_read, m_write, i_resp, d_resp, m_addr);
         end
         next_cycle();
      end
   endtask

   task automatic test_fetch;
      i_read = 1; i_addr = 16'h0040;
      mid();
      tests++;
      if (m_read !== 1'b0) begin fails++; $display("FAIL fetch_req_cycle: m_read=%b, required 0", m_read); end
      next_cycle();
      for (int c = 1; c <= 3; c++) begin
         mid();
         tests++;
         if (m_read !== 1'b1 || m_addr !== 16'h0040 || m_write !== 1'b0 || i_resp !== 1'b0) begin
            fails++;
            $display("FAIL fetch_wait c%0d: rd=%b wr=%b addr=%h ir=%b, required 1 0 0040 0", c, m_read, m_write, m_addr, i_resp);
         end
         next_cycle();
      end
      m_resp = 1; m_rdata = PAT_A5;
      mid();
      tests++;
      if (i_resp !== 1'b1 || i_rdata !== PAT_A5 || d_resp !== 1'b0) begin
         fails++;
         $display("FAIL fetch_resp: ir=%b dr=%b rdata=%h, required 1 0 %h", i_resp, d_resp, i_rdata, PAT_A5);
      end
      next_cycle();
      clear_inputs();
      mid();
      tests++;
      if (m_read !== 1'b0 || i_resp !== 1'b0 || m_addr !== 16'h0) begin
         fails++;
         $display("FAIL fetch_idle_after: rd=%b ir=%b addr=%h, required 0 0 0000", m_read, i_resp, m_addr);
      end
      next_cycle();
   endtask

   task automatic test_write;
      d_write = 1; d_addr = 16'h1000; d_wdata = PAT_WD;
      mid();
      tests++;
      if (m_write !== 1'b0 || m_read !== 1'b0) begin fails++; $display("FAIL write_req_cycle: wr=%b rd=%b, required 0 0", m_write, m_read); end
      next_cycle();
      m_resp = 1;
      mid();
      tests++;
      if (m_write !== 1'b1 || m_read !== 1'b0 || m_addr !== 16'h1000 || m_wdata !== PAT_WD || d_resp !== 1'b1 || i_resp !== 1'b0) begin
         fails++;
         $display("FAIL write_grant: wr=%b rd=%b addr=%h dr=%b ir=%b wdata=%h, required 1 0 1000 1 0 %h", m_write, m_read, m_addr, d_resp, i_resp, m_wdata, PAT_WD);
      end
      next_cycle();
      clear_inputs();
      mid();
      tests++;
      if (m_write !== 1'b0 || m_read !== 1'b0 || d_resp !== 1'b0) begin
         fails++;
         $display("FAIL write_after: wr=%b rd=%b dr=%b, required 0 0 0", m_write, m_read, d_resp);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back;
      i_read = 1; i_addr = 16'h0050; d_read = 1; d_addr = 16'h2000;
      next_cycle();
      m_resp = 1; m_rdata = 128'h1;
      mid();
      tests++;
      if (m_read !== 1'b1 || m_addr !== 16'h2000 || d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== 128'h1) begin
         fails++;
         $display("FAIL b2b_data_first: rd=%b addr=%h dr=%b ir=%b, required 1 2000 1 0", m_read, m_addr, d_resp, i_resp);
      end
      next_cycle();
      d_read = 0; m_resp = 0;
      mid();
      tests++;
      if (m_read !== 1'b0 || m_addr !== 16'h0) begin
         fails++;
         $display("FAIL b2b_gap: rd=%b addr=%h, required 0 0000", m_read, m_addr);
      end
      next_cycle();
      m_resp = 1;
      mid();
      tests++;
      if (m_read !== 1'b1 || m_addr !== 16'h0050 || i_resp !== 1'b1 || d_resp !== 1'b0) begin
         fails++;
         $display("FAIL b2b_fetch_second: rd=%b addr=%h ir=%b dr=%b, required 1 0050 1 0", m_read, m_addr, i_resp, d_resp);
      end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_starve;
      int n_i, n_d;
      logic [5:0] seq;
      int g;
      clear_inputs();
      rst = 1;
      next_cycle();
      rst = 0;
      i_read = 1; i_addr = 16'h0050; d_read = 1; d_addr = 16'h2000; m_resp = 1;
      n_i = 0; n_d = 0; seq = '0; g = 0;
      for (int c = 0; c < 20; c++) begin
         mid();
         if (m_read && m_addr == 16'h0050) begin n_i++; if (g < 6) seq[g] = 1'b1; g++; end
         if (m_read && m_addr == 16'h2000) begin n_d++; g++; end
         next_cycle();
      end
      clear_inputs();
      next_cycle();
`ifdef MEM_ARB_STARVE_GUARD_EN
      tests++;
      if (seq !== 6'b010000) begin fails++; $display("FAIL starve_order: grant bits=%b, required 010000", seq); end
      tests++;
      if (n_i !== 2 || n_d !== 8) begin fails++; $display("FAIL starve_counts: fetch=%0d data=%0d, required 2 8", n_i, n_d); end
`else
      tests++;
      if (n_i !== 0 || n_d !== 10 || seq !== 6'b0) begin fails++; $display("FAIL strict_priority: fetch=%0d data=%0d, required 0 10", n_i, n_d); end
`endif
   endtask

   task automatic test_reset_inflight;
      d_read = 1; d_addr = 16'h3000;
      next_cycle();
      mid();
      tests++;
      if (m_read !== 1'b1 || m_addr !== 16'h3000) begin fails++; $display("FAIL rst_pre_grant: rd=%b addr=%h, required 1 3000", m_read, m_addr); end
      next_cycle();
      rst = 1;
      next_cycle();
      rst = 0; d_read = 0; m_resp = 1;
      mid();
      tests++;
      if (m_read !== 1'b0 || d_resp !== 1'b0 || m_addr !== 16'h0) begin
         fails++;
         $display("FAIL rst_abandon: rd=%b dr=%b addr=%h, required 0 0 0000", m_read, d_resp, m_addr);
      end
      next_cycle();
      m_resp = 0;
      mid();
      tests++;
      if (d_resp !== 1'b0 || m_read !== 1'b0 || m_write !== 1'b0) begin
         fails++;
         $display("FAIL rst_late_resp: dr=%b rd=%b wr=%b, required 0 0 0", d_resp, m_read, m_write);
      end
      next_cycle();
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_fetch();
      test_write();
      test_back_to_back();
      test_starve();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port to one-port memory arbiter between the pipeline's instruction-fetch port and data (MEM-stage) port and the single shared downstream memory (L2 / physical memory). The block grants one requester at a time and holds the grant until the downstream response. It returns read data and the response to the granted requester only. The fetch and data caches plug in unchanged; only one memory interface leaves the core.

## Interface
Parameters:
- ADDR_W, 16, address width (lc3b_word).
- DATA_W, 128, transfer width (one cache line).
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (only with the starvation guard).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_read  in  1  fetch-side read request, held until i_resp.
- i_addr  in  ADDR_W  fetch-side address.
- i_rdata  out  DATA_W  fetch-side read data; valid when i_resp.
- i_resp  out  1  fetch-side completion, one cycle.
- d_read  in  1  data-side read request, held until d_resp.
- d_write  in  1  data-side write request, held until d_resp.
- d_addr  in  ADDR_W  data-side address.
- d_wdata  in  DATA_W  data-side write data.
- d_rdata  out  DATA_W  data-side read data; valid when d_resp.
- d_resp  out  1  data-side completion, one cycle.
- m_read  out  1  downstream read strobe.
- m_write  out  1  downstream write strobe.
- m_addr  out  ADDR_W  downstream address.
- m_wdata  out  DATA_W  downstream write data.
- m_rdata  in  DATA_W  downstream read data.
- m_resp  in  1  downstream completion, one cycle.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - m_read, m_write, i_resp and d_resp are 0; m_addr and m_wdata are 0.
  - If (d_read|d_write), go to GRANT_D.
  - Otherwise, if i_read, go to GRANT_I.
  - Otherwise, stay in IDLE.
- GRANT_D:
  - m_read=d_read and m_write=d_write, combinational from the held request.
  - m_addr=d_addr; m_wdata=d_wdata.
  - On m_resp, d_resp=1 in the same cycle and the next state is IDLE.
- GRANT_I:
  - m_read=i_read; m_write=0; m_addr=i_addr; m_wdata=0.
  - On m_resp, i_resp=1 in the same cycle and the next state is IDLE.
- i_rdata and d_rdata are both wired to m_rdata. Only the granted requester's resp qualifies the data.
- The mandatory return to IDLE after every response gives one idle cycle with the downstream strobes low. It also lets the requester drop its request, so a stale request is never re-served.
- d_read and d_write both high is illegal. Write takes precedence: m_write=1, m_read=0. A simulation assertion flags it.
- A requester that drops its request before resp is illegal. The arbiter stays in its grant state until m_resp regardless.
- m_resp in IDLE is ignored and produces no x_resp.
- rst in any state:
  - Next state is IDLE and all outputs are at their IDLE values from the next cycle.
  - Any in-flight downstream transaction is abandoned; a late m_resp lands in IDLE and is ignored.
  - The starvation counter clears to 0.

## Timing
- A request sampled in IDLE at edge N drives m_read/m_write during cycle N+1.
- m_resp during cycle K gives x_resp during cycle K; the state is IDLE in K+1; the earliest next grant is K+2.
- Minimum request-to-resp latency is 2 cycles with a zero-wait downstream (m_resp in the first granted cycle).
- No output is registered except through the state.
- Request-to-strobe is one edge; resp-to-resp is combinational.
- Fetch and data requests raised in the same IDLE cycle: data is granted first, and fetch is granted at the earliest 2 cycles after d_resp.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter (width clog2(STARVE_LIMIT+1)) increments on each IDLE→GRANT_D taken while i_read=1.
  - It clears on IDLE→GRANT_I.
  - When the counter equals STARVE_LIMIT and both sides request in IDLE, GRANT_I is taken instead of GRANT_D.
- MEM_ARB_STARVE_GUARD_EN undefined: strict data priority; no counter logic exists.

## Test plan
- Reset, then idle 5 cycles: m_read=m_write=i_resp=d_resp=0; m_addr=0.
- i_read=1, i_addr=0x0040, memory responds 3 cycles after the strobe with m_rdata=0xA5…A5 → m_read high from the cycle after the request with m_addr=0x0040; i_resp=1 with i_rdata=0xA5…A5; d_resp stays 0; one idle cycle follows.
- d_write=1, d_addr=0x1000, d_wdata=0x1234…, zero-wait memory → m_write=1 with m_addr=0x1000 for exactly one cycle; d_resp=1 in that cycle; m_read=0 throughout.
- i_read and d_read rise in the same cycle (0x0050 / 0x2000) → data served first (m_addr=0x2000), then fetch (m_addr=0x0050) granted exactly 2 cycles after d_resp.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, d_read held continuously and i_read held → 4 data grants, then one fetch grant, then data resumes. Without the macro, no fetch grant occurs while d_read is held.
- rst asserted two cycles into a GRANT_D read, memory asserts m_resp after reset → state IDLE, m_read=0 the cycle after rst, and d_resp never asserts.
